md5_compress_iter: RTL



---
 rtl/md5_compress_iter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/md5_compress_iter.sv
// Multi-cycle MD5 compression core: STEPS_PER_CYCLE steps per clock, then feed-forward.
// Optional MD5_IV_SEL_EN adds use_iv to load the standard IV instead of h_in.
module md5_compress_iter #(
   parameter int unsigned STEPS_PER_CYCLE = 1,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [511:0]     blk,
   input  logic [127:0]     h_in,
`ifdef MD5_IV_SEL_EN
   input  logic             use_iv,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     h_out,
   output logic             busy,
   output logic [5:0]       step_idx,
   output logic [CNT_W-1:0] blk_count
);

   localparam int unsigned W     = 32;
   localparam int unsigned ST_W  = 4 * W;
   localparam int unsigned IDX_W = 6;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(64 - STEPS_PER_CYCLE);
   localparam logic [IDX_W-1:0] IDX_INC  = IDX_W'(STEPS_PER_CYCLE);

   generate
      if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
            STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : g_bad_steps
         $error("STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [W-1:0] K_TAB [0:63] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Rotate amounts per round, indexed by i mod 4 (5 bits each, entry 0 in the LSBs).
   localparam logic [19:0] ROT_R0 = {5'd22, 5'd17, 5'd12, 5'd7};
   localparam logic [19:0] ROT_R1 = {5'd20, 5'd14, 5'd9,  5'd5};
   localparam logic [19:0] ROT_R2 = {5'd23, 5'd16, 5'd11, 5'd4};
   localparam logic [19:0] ROT_R3 = {5'd21, 5'd15, 5'd10, 5'd6};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [511:0]      m_q;
   logic [ST_W-1:0]   hsave_q;
   logic [ST_W-1:0]   st_q;
   logic [ST_W-1:0]   st_d;
   logic [ST_W-1:0]   h_sel;
   logic              accept, last, handoff;

   // One MD5 step; state packed {d,c,b,a}.
   function automatic logic [ST_W-1:0] md5_step(input logic [ST_W-1:0] st,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [511:0] m);
      logic [W-1:0]   a, b, c, d, f, tmp;
      logic [3:0]     g;
      logic [4:0]     s;
      logic [2*W-1:0] dbl;
      a = st[W-1:0];
      b = st[2*W-1:W];
      c = st[3*W-1:2*W];
      d = st[4*W-1:3*W];
      case (i[5:4])
         2'd0: begin f = (b & c) | (~b & d); g = i[3:0];                    s = ROT_R0[5*i[1:0] +: 5]; end
         2'd1: begin f = (b & d) | (c & ~d); g = 4'(i[3:0] * 4'd5 + 4'd1);  s = ROT_R1[5*i[1:0] +: 5]; end
         2'd2: begin f = b ^ c ^ d;          g = 4'(i[3:0] * 4'd3 + 4'd5);  s = ROT_R2[5*i[1:0] +: 5]; end
         default: begin f = c ^ (b | ~d);    g = 4'(i[3:0] * 4'd7);         s = ROT_R3[5*i[1:0] +: 5]; end
      endcase
      tmp = a + f + K_TAB[i] + m[{g, 5'd0} +: W];
      dbl = {tmp, tmp} << s;
      return {c, b, b + dbl[2*W-1:W], d};
   endfunction

   always_comb begin
      h_sel = h_in;
`ifdef MD5_IV_SEL_EN
      if (use_iv) h_sel = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
`endif
   end

   // Chain the steps executed on this edge.
   always_comb begin
      st_d = st_q;
      for (int k = 0; k < int'(STEPS_PER_CYCLE); k++) begin
         st_d = md5_step(st_d, IDX_W'(step_idx + IDX_W'(k)), m_q);
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      handoff = 1'b0;
      case (state_q)
         IDLE: if (in_valid && in_ready) begin accept = 1'b1; state_d = RUN; end
         RUN:  if (step_idx == LAST_IDX) begin last = 1'b1; state_d = DONE; end
         DONE: if (out_ready) begin handoff = 1'b1; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         h_out     <= '0;
         step_idx  <= '0;
         blk_count <= '0;
         m_q       <= '0;
         hsave_q   <= '0;
         st_q      <= '0;
      end else begin
         in_ready <= (state_d == IDLE);
         busy     <= (state_d != IDLE);
         if (accept) begin
            m_q      <= blk;
            hsave_q  <= h_sel;
            st_q     <= h_sel;
            step_idx <= '0;
         end else if (state_q == RUN) begin
            st_q     <= st_d;
            step_idx <= last ? '0 : IDX_W'(step_idx + IDX_INC);
         end
         // Feed-forward addition on the edge that runs step 63.
         if (last) begin
            h_out     <= {st_d[4*W-1:3*W] + hsave_q[4*W-1:3*W],
                          st_d[3*W-1:2*W] + hsave_q[3*W-1:2*W],
                          st_d[2*W-1:W]   + hsave_q[2*W-1:W],
                          st_d[W-1:0]     + hsave_q[W-1:0]};
            out_valid <= 1'b1;
         end
         if (handoff) begin
            out_valid <= 1'b0;
            blk_count <= CNT_W'(blk_count + 1'b1);
         end
      end
   end

endmodule
